issue_arbiter: RTL and testbench
================================

ISSUE_ARBITER -- requirements
Module: issue_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 137: width of one issue-queue / load-store-queue head entry.
REQ-002 Parameter ROBINDEX, default 6: ROB pointer width; the pointer lives in entry bits [ROBINDEX+31:32].
REQ-003 Parameter STARVE_LIMIT, default 4: max consecutive wins by one queue while the other requests.
REQ-004 CLK  in  1  clock; all state updates on the rising edge.
REQ-005 RESET  in  1  reset, asynchronous, active-low.
REQ-006 FREEZE  in  1  downstream stall; hold all state.
REQ-007 FLUSH  in  1  synchronous pipeline flush.
REQ-008 rob_head  in  ROBINDEX  current ROB head pointer (oldest in flight).
REQ-009 iq_req  in  1  issue-queue head valid and ready.
REQ-010 iq_data  in  DATA_WIDTH  issue-queue head entry.
REQ-011 lsq_req  in  1  load-store-queue head valid and ready.
REQ-012 lsq_data  in  DATA_WIDTH  load-store-queue head entry.
REQ-013 iq_pop  out  1  combinational pop strobe to the issue queue.
REQ-014 lsq_pop  out  1  combinational pop strobe to the load-store queue.
REQ-015 out_data  out  DATA_WIDTH  registered granted entry to the register-read stage.
REQ-016 out_valid  out  1  registered; out_data holds a real instruction.
REQ-017 out_mem  out  1  registered; 1 = entry came from the LSQ.
REQ-018 iq_grants, lsq_grants  out  32 each  wrapping grant counters.

Function
REQ-019 Age of an entry SHALL be (rob_ptr - rob_head) mod 2^ROBINDEX; smaller age is older.
REQ-020 Policy FSM SHALL have states AGE, FORCE_IQ, FORCE_LSQ.
REQ-021 In AGE with both requesting, the older entry SHALL win; on equal age the LSQ SHALL win.
REQ-022 In any state, if exactly one queue requests, it SHALL win.
REQ-023 In FORCE_IQ / FORCE_LSQ with both requesting, the named queue SHALL win regardless of age.
REQ-024 A 3-bit streak counter and streak owner SHALL track consecutive wins of one queue made while the other queue also requested.
REQ-025 A win with only one queue requesting SHALL clear the streak to 0.
REQ-026 A win by the queue other than the streak owner SHALL set the owner to the winner and the streak to 1.
REQ-027 When a contested win brings the streak to STARVE_LIMIT, the FSM SHALL move to FORCE_<other queue> for the next cycle and clear the streak.
REQ-028 After a forced grant, or any cycle in a FORCE state with a single requester, the FSM SHALL return to AGE.
REQ-029 The pop to the winner SHALL assert in the same cycle as the grant, only when !FREEZE and !FLUSH, and at most one pop SHALL be high per cycle.
REQ-030 On a rising edge with a grant, out_data SHALL take the winner's data, out_valid SHALL be 1 and out_mem SHALL equal (winner==LSQ); the winner's grant counter SHALL increment by 1.
REQ-031 On a rising edge with !FREEZE and no request, out_valid SHALL be 0, and out_data and out_mem SHALL hold.
REQ-032 With FREEZE=1 and FLUSH=0, pops SHALL be 0 and all registers, the FSM state and the counters SHALL hold.
REQ-033 FLUSH=1 SHALL override FREEZE: pops 0, and at the edge out_valid 0, FSM to AGE, streak 0; grant counters hold.
REQ-034 Latency SHALL be one cycle from the pop to out_valid.

Reset
REQ-035 While RESET=0: out_data 0, out_valid 0, out_mem 0, FSM AGE, streak 0, streak owner IQ, both grant counters 0.
REQ-036 Pops SHALL be 0 while RESET=0; reset asserted mid-operation SHALL discard the in-flight grant with no pop.

Verification
REQ-037 Only iq_req, rob ptr 5, rob_head 0 -> iq_pop=1; next cycle out_valid=1, out_mem=0, iq_grants=1.
REQ-038 Both request, IQ ptr 2, LSQ ptr 62, rob_head 60 -> LSQ older (age 2 vs 6): lsq_pop=1, out_mem=1.
REQ-039 Both requesting continuously, IQ always older, STARVE_LIMIT=4 -> grants IQ,IQ,IQ,IQ,LSQ,IQ...
REQ-040 FREEZE high for 3 cycles with both requesting -> no pops, outputs and counters unchanged; the first cycle after release grants per policy.
REQ-041 FLUSH together with FREEZE while out_valid=1 -> no pop; next edge out_valid=0, FSM AGE.
REQ-042 RESET low mid-stream -> all outputs 0 immediately, pops 0.

Source files
------------

// File: rtl/issue_arbiter_if.sv
// rtl/issue_arbiter_if.sv - queue-head requests, pop strobes and granted-entry output of the issue arbiter
interface issue_arbiter_if #(
   parameter int DATA_WIDTH = 137
);
   logic                  iq_req;
   logic [DATA_WIDTH-1:0] iq_data;
   logic                  iq_pop;
   logic                  lsq_req;
   logic [DATA_WIDTH-1:0] lsq_data;
   logic                  lsq_pop;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_mem;

   modport master (
      input  iq_req, iq_data, lsq_req, lsq_data,
      output iq_pop, lsq_pop, out_data, out_valid, out_mem
   );

   modport slave (
      output iq_req, iq_data, lsq_req, lsq_data,
      input  iq_pop, lsq_pop, out_data, out_valid, out_mem
   );
endinterface

// File: rtl/issue_arbiter.sv
// rtl/issue_arbiter.sv - age-ordered IQ/LSQ issue arbiter with anti-starvation forcing
module issue_arbiter #(
   parameter int DATA_WIDTH   = 137,
   parameter int ROBINDEX     = 6,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                FREEZE,
   input  logic                FLUSH,
   input  logic [ROBINDEX-1:0] rob_head,
   issue_arbiter_if.master     arb,
   output logic [31:0]         iq_grants,
   output logic [31:0]         lsq_grants
);
   localparam logic [1:0] ST_AGE       = 2'd0;
   localparam logic [1:0] ST_FORCE_IQ  = 2'd1;
   localparam logic [1:0] ST_FORCE_LSQ = 2'd2;
   localparam logic [2:0] STREAK_MAX   = 3'(STARVE_LIMIT);

   logic [1:0]          state, state_nxt;
   logic [2:0]          streak, streak_nxt, streak_inc;
   logic                owner_lsq, owner_nxt;
   logic [ROBINDEX-1:0] iq_age, lsq_age;
   logic                contested, grant, win_lsq, advance;

   // Distance from the ROB head, modulo the pointer width, orders entries by age.
   assign iq_age    = arb.iq_data[ROBINDEX+31:32] - rob_head;
   assign lsq_age   = arb.lsq_data[ROBINDEX+31:32] - rob_head;
   assign contested = arb.iq_req & arb.lsq_req;
   assign grant     = arb.iq_req | arb.lsq_req;
   assign advance   = RESET & ~FREEZE & ~FLUSH;

   always_comb begin
      win_lsq = 1'b0;
      if (contested) begin
         case (state)
            ST_FORCE_IQ:  win_lsq = 1'b0;
            ST_FORCE_LSQ: win_lsq = 1'b1;
            default:      win_lsq = (lsq_age <= iq_age);
         endcase
      end else begin
         win_lsq = arb.lsq_req;
      end
   end

   assign arb.iq_pop  = advance & grant & ~win_lsq;
   assign arb.lsq_pop = advance & grant & win_lsq;

   assign streak_inc = (win_lsq == owner_lsq) ? streak + 3'd1 : 3'd1;

   // Only contested wins build a streak; reaching the limit hands the next contested slot to the loser.
   always_comb begin
      state_nxt  = state;
      streak_nxt = streak;
      owner_nxt  = owner_lsq;
      if (grant) begin
         state_nxt = ST_AGE;
         if (contested) begin
            owner_nxt = win_lsq;
            if (streak_inc == STREAK_MAX) begin
               state_nxt  = win_lsq ? ST_FORCE_IQ : ST_FORCE_LSQ;
               streak_nxt = 3'd0;
            end else begin
               streak_nxt = streak_inc;
            end
         end else begin
            streak_nxt = 3'd0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state         <= ST_AGE;
         streak        <= 3'd0;
         owner_lsq     <= 1'b0;
         arb.out_data  <= '0;
         arb.out_valid <= 1'b0;
         arb.out_mem   <= 1'b0;
         iq_grants     <= 32'd0;
         lsq_grants    <= 32'd0;
      end else if (FLUSH) begin
         state         <= ST_AGE;
         streak        <= 3'd0;
         arb.out_valid <= 1'b0;
      end else if (!FREEZE) begin
         state         <= state_nxt;
         streak        <= streak_nxt;
         owner_lsq     <= owner_nxt;
         arb.out_valid <= grant;
         if (grant) begin
            arb.out_data <= win_lsq ? arb.lsq_data : arb.iq_data;
            arb.out_mem  <= win_lsq;
            if (win_lsq)
               lsq_grants <= lsq_grants + 32'd1;
            else
               iq_grants <= iq_grants + 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_issue_arbiter.sv
// tb/tb_issue_arbiter.sv - randomized scoreboard bench for issue_arbiter
module tb_issue_arbiter;
   localparam int DW  = 137;
   localparam int RI  = 6;
   localparam int LIM = 4;

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic          FREEZE = 1'b0;
   logic          FLUSH = 1'b0;
   logic [RI-1:0] rob_head = '0;
   logic [31:0]   iq_grants, lsq_grants;

   issue_arbiter_if #(.DATA_WIDTH(DW)) bus ();

   issue_arbiter #(.DATA_WIDTH(DW), .ROBINDEX(RI), .STARVE_LIMIT(LIM)) dut (
      .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH(FLUSH), .rob_head(rob_head),
      .arb(bus.master), .iq_grants(iq_grants), .lsq_grants(lsq_grants)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic          valid;
      logic [DW-1:0] data;
      logic          mem;
      logic [31:0]   ic;
      logic [31:0]   lc;
   } exp_t;

   exp_t exp_q[$];
   exp_t last;
   logic last_data_known;
   int   checks = 0;
   int   errors = 0;

   // Reference policy: mode 0 = oldest wins, 1 = IQ must win, 2 = LSQ must win.
   int          m_mode, m_run, m_owner;
   logic [31:0] m_ic, m_lc;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_entry(input int ptr);
      logic [DW-1:0] e;
      for (int i = 0; i < DW; i++) e[i] = 1'($urandom_range(0, 1));
      e[RI+31:32] = RI'(ptr);
      return e;
   endfunction

   function automatic int age(input int p, input int h);
      return (p - h + (1 << RI)) % (1 << RI);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_run = 0; m_owner = 0; m_ic = 0; m_lc = 0;
      last = '{1'b0, '0, 1'b0, 32'd0, 32'd0};
      last_data_known = 1'b1;
      exp_q.delete();
   endtask

   task automatic drive(input logic iq_r, input int iq_p, input logic lsq_r, input int lsq_p,
                        input int head, input logic frz, input logic fl,
                        output logic got_iq, output logic got_lsq);
      logic [DW-1:0] iq_e, lsq_e;
      int   win;
      logic act;
      iq_e  = mk_entry(iq_p);
      lsq_e = mk_entry(lsq_p);
      @(negedge CLK);
      RESET = 1'b1;
      bus.iq_req = iq_r;  bus.iq_data = iq_e;
      bus.lsq_req = lsq_r; bus.lsq_data = lsq_e;
      rob_head = RI'(head);
      FREEZE = frz; FLUSH = fl;
      #1;
      win = -1;
      if (iq_r && lsq_r) begin
         if (m_mode == 1) win = 0;
         else if (m_mode == 2) win = 1;
         else win = (age(lsq_p, head) <= age(iq_p, head)) ? 1 : 0;
      end else if (iq_r) win = 0;
      else if (lsq_r) win = 1;
      act = !frz && !fl;
      got_iq = bus.iq_pop;
      got_lsq = bus.lsq_pop;
      chk("iq_pop", DW'(bus.iq_pop), DW'(act && win == 0));
      chk("lsq_pop", DW'(bus.lsq_pop), DW'(act && win == 1));
      if (fl) begin
         m_mode = 0; m_run = 0;
      end else if (!frz) begin
         if (win >= 0) begin
            if (win == 0) m_ic++; else m_lc++;
            if (iq_r && lsq_r) begin
               m_run = (win == m_owner) ? m_run + 1 : 1;
               m_owner = win;
               m_mode = 0;
               if (m_run == LIM) begin
                  m_mode = (win == 0) ? 2 : 1;
                  m_run = 0;
               end
            end else begin
               m_run = 0; m_mode = 0;
            end
            exp_q.push_back('{1'b1, (win == 1) ? lsq_e : iq_e, win == 1, m_ic, m_lc});
         end else begin
            exp_q.push_back('{1'b0, '0, 1'b0, m_ic, m_lc});
         end
      end
   endtask

   task automatic reset_mid();
      @(negedge CLK);
      bus.iq_req = 1'b1; bus.lsq_req = 1'b1;
      RESET = 1'b0;
      #1;
      chk("rst_out_valid", DW'(bus.out_valid), '0);
      chk("rst_out_data", bus.out_data, '0);
      chk("rst_out_mem", DW'(bus.out_mem), '0);
      chk("rst_iq_pop", DW'(bus.iq_pop), '0);
      chk("rst_lsq_pop", DW'(bus.lsq_pop), '0);
      chk("rst_iq_grants", DW'(iq_grants), '0);
      chk("rst_lsq_grants", DW'(lsq_grants), '0);
      model_reset();
   endtask

   // Monitor: one expectation per advancing edge; frozen and flushed edges are checked against held state.
   initial begin
      exp_t e;
      logic s_rst, s_frz, s_fl;
      forever begin
         @(posedge CLK);
         s_rst = RESET; s_frz = FREEZE; s_fl = FLUSH;
         #1;
         if (!s_rst) begin
         end else if (s_fl) begin
            chk("flush_out_valid", DW'(bus.out_valid), '0);
            chk("flush_iq_grants", DW'(iq_grants), DW'(last.ic));
            chk("flush_lsq_grants", DW'(lsq_grants), DW'(last.lc));
            last.valid = 1'b0;
            last_data_known = 1'b0;
         end else if (s_frz) begin
            chk("frz_out_valid", DW'(bus.out_valid), DW'(last.valid));
            chk("frz_iq_grants", DW'(iq_grants), DW'(last.ic));
            chk("frz_lsq_grants", DW'(lsq_grants), DW'(last.lc));
            if (last_data_known) begin
               chk("frz_out_data", bus.out_data, last.data);
               chk("frz_out_mem", DW'(bus.out_mem), DW'(last.mem));
            end
         end else if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got out_valid=%0b with no expectation queued", bus.out_valid);
         end else begin
            e = exp_q.pop_front();
            chk("out_valid", DW'(bus.out_valid), DW'(e.valid));
            chk("iq_grants", DW'(iq_grants), DW'(e.ic));
            chk("lsq_grants", DW'(lsq_grants), DW'(e.lc));
            last.valid = e.valid; last.ic = e.ic; last.lc = e.lc;
            if (e.valid) begin
               chk("out_data", bus.out_data, e.data);
               chk("out_mem", DW'(bus.out_mem), DW'(e.mem));
               last.data = e.data; last.mem = e.mem;
               last_data_known = 1'b1;
            end else if (last_data_known) begin
               chk("idle_out_data", bus.out_data, last.data);
               chk("idle_out_mem", DW'(bus.out_mem), DW'(last.mem));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   initial begin
      logic gi, gl;
      int   pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      int   ip, lp;
      model_reset();
      bus.iq_req = 1'b1; bus.lsq_req = 1'b1;
      bus.iq_data = '0; bus.lsq_data = '0;
      #2;
      chk("init_out_valid", DW'(bus.out_valid), '0);
      chk("init_out_data", bus.out_data, '0);
      chk("init_out_mem", DW'(bus.out_mem), '0);
      chk("init_iq_pop", DW'(bus.iq_pop), '0);
      chk("init_lsq_pop", DW'(bus.lsq_pop), '0);
      chk("init_iq_grants", DW'(iq_grants), '0);
      chk("init_lsq_grants", DW'(lsq_grants), '0);

      drive(1, 5, 0, 0, 0, 0, 0, gi, gl);
      chk("single_iq_pop", DW'(gi), DW'(1));
      drive(0, 0, 0, 0, 0, 0, 0, gi, gl);
      chk("single_iq_grants", DW'(iq_grants), DW'(1));

      drive(0, 0, 0, 0, 0, 0, 1, gi, gl);
      drive(1, 2, 1, 62, 60, 0, 0, gi, gl);
      chk("wrap_age_lsq_pop", DW'(gl), DW'(1));
      chk("wrap_age_iq_pop", DW'(gi), DW'(0));
      drive(0, 0, 0, 0, 0, 0, 0, gi, gl);
      chk("wrap_age_out_mem", DW'(bus.out_mem), DW'(1));

      drive(0, 0, 0, 0, 0, 0, 1, gi, gl);
      for (int i = 0; i < 10; i++) begin
         drive(1, 10, 1, 20, 8, 0, 0, gi, gl);
         chk("starve_lsq_pop", DW'(gl), DW'(pat[i]));
      end

      for (int i = 0; i < 3; i++) drive(1, 30, 1, 31, 28, 1, 0, gi, gl);
      drive(1, 30, 1, 31, 28, 0, 0, gi, gl);

      drive(1, 7, 0, 0, 0, 0, 0, gi, gl);
      drive(1, 7, 1, 3, 0, 1, 1, gi, gl);
      drive(1, 7, 1, 3, 0, 0, 0, gi, gl);
      chk("post_flush_lsq_pop", DW'(gl), DW'(1));

      drive(1, 9, 1, 4, 0, 0, 0, gi, gl);
      reset_mid();
      drive(0, 0, 1, 8, 0, 0, 0, gi, gl);

      for (int n = 0; n < 500; n++) begin
         ip = $urandom_range(0, (1 << RI) - 1);
         lp = ($urandom_range(0, 3) == 0) ? ip : $urandom_range(0, (1 << RI) - 1);
         drive(1'($urandom_range(0, 3) != 0), ip, 1'($urandom_range(0, 3) != 0), lp,
               $urandom_range(0, (1 << RI) - 1), 1'($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 15) == 0), gi, gl);
      end

      drive(0, 0, 0, 0, 0, 0, 0, gi, gl);
      drive(0, 0, 0, 0, 0, 0, 0, gi, gl);
      @(negedge CLK);
      chk("scoreboard_drained", DW'(exp_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
